// File: rtl/multiply_pkg.sv
// Shared definitions for the AXI-Lite sequential multiplier: register word
// offsets, CTRL bit positions, response codes and core iteration count.
package multiply_pkg;

    localparam int DATA_W     = 32;
    localparam int ITERATIONS = 32;
    localparam int ITER_W     = $clog2(ITERATIONS);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERATIONS - 1);

    // Word indices (byte address bits [4:2])
    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RES_LO = 3'd3;
    localparam logic [2:0] REG_RES_HI = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } core_state_t;

    function automatic logic is_mapped(input logic [2:0] idx);
        return idx <= REG_RES_HI;
    endfunction

endpackage

// File: rtl/multiply_seq_core.sv
// Unsigned 32x32->64 shift-add multiplier, one multiplier bit per cycle.
// Latency: 32 RUN cycles after start; product/finish land on the last one.
// Backpressure: none; start is ignored while busy.
module multiply_seq_core
    import multiply_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    output logic                busy,
    output logic                finish,
    output logic [2*DATA_W-1:0] product
);

    core_state_t          state;
    logic [ITER_W-1:0]    cnt;
    logic [2*DATA_W-1:0]  acc;
    logic [2*DATA_W-1:0]  mcand;
    logic [DATA_W-1:0]    mplier;
    logic [2*DATA_W-1:0]  next_acc;

    assign next_acc = acc + (mplier[0] ? mcand : '0);
    assign busy     = (state == ST_RUN);
    // Combinational so the top can set DONE on the same edge the product lands
    assign finish   = (state == ST_RUN) && (cnt == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{DATA_W{1'b0}}, opa};
                        mplier <= opb;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc    <= next_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        product <= next_acc;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/multiply_axi_slave.sv
// AXI-Lite register front end for the sequential multiplier core.
// Latency: B/R valid one cycle after the READY pulse; product 33 cycles after START.
// Backpressure: no new AW/W or AR accepted until the pending B or R is drained.
module multiply_axi_slave
    import multiply_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    logic                 aw_rdy;
    logic                 b_vld;
    logic [1:0]           b_resp;
    logic                 ar_rdy;
    logic                 r_vld;
    logic [1:0]           r_resp;
    logic [DATA_W-1:0]    r_dat;
    logic [DATA_W-1:0]    opa;
    logic [DATA_W-1:0]    opb;
    logic                 ctrl_done;
    logic                 core_busy;
    logic                 core_finish;
    logic [2*DATA_W-1:0]  product;
    logic [2:0]           wr_idx;
    logic [2:0]           rd_idx;
    logic                 wr_en;
    logic                 rd_en;
    logic                 ctrl_wr;
    logic                 start_fire;
    logic [DATA_W-1:0]    rd_mux_dat;
    logic [1:0]           rd_mux_resp;
    logic                 unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx     = S_AXI_AWADDR[4:2];
    assign rd_idx     = S_AXI_ARADDR[4:2];
    assign wr_en      = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en      = ar_rdy && S_AXI_ARVALID;
    assign ctrl_wr    = wr_en && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0];
    assign start_fire = ctrl_wr && S_AXI_WDATA[CTRL_START] && !core_busy;

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = aw_rdy;
    assign S_AXI_BVALID  = b_vld;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_RVALID  = r_vld;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = r_dat;

    // Write channel: AW and W are accepted together in one READY pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            b_resp <= RESP_OKAY;
        end else begin
            aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !b_vld;
            if (wr_en) begin
                b_vld  <= 1'b1;
                b_resp <= is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
            end else if (b_vld && S_AXI_BREADY) begin
                b_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux_dat  = '0;
        rd_mux_resp = RESP_OKAY;
        case (rd_idx)
            REG_OPA:    rd_mux_dat = opa;
            REG_OPB:    rd_mux_dat = opb;
            REG_CTRL: begin
                rd_mux_dat[CTRL_BUSY] = core_busy;
                rd_mux_dat[CTRL_DONE] = ctrl_done;
            end
            REG_RES_LO: rd_mux_dat = product[DATA_W-1:0];
            REG_RES_HI: rd_mux_dat = product[2*DATA_W-1:DATA_W];
            default:    rd_mux_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_resp <= RESP_OKAY;
            r_dat  <= '0;
        end else begin
            ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_vld;
            if (rd_en) begin
                r_vld  <= 1'b1;
                r_dat  <= rd_mux_dat;
                r_resp <= rd_mux_resp;
            end else if (r_vld && S_AXI_RREADY) begin
                r_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            opa <= '0;
            opb <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    if (wr_idx == REG_OPA) opa[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    if (wr_idx == REG_OPB) opb[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Completion outranks a same-cycle write-1-to-clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_done <= 1'b0;
        end else if (core_finish) begin
            ctrl_done <= 1'b1;
        end else if (start_fire || (ctrl_wr && S_AXI_WDATA[CTRL_DONE])) begin
            ctrl_done <= 1'b0;
        end
    end

    multiply_seq_core u_core (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .start   (start_fire),
        .opa     (opa),
        .opb     (opb),
        .busy    (core_busy),
        .finish  (core_finish),
        .product (product)
    );

endmodule

// File: tb/tb_multiply_axi_slave.sv
// Directed bench for multiply_axi_slave with a read/write-response scoreboard.
module tb_multiply_axi_slave;

    localparam int LIM = 60;

    logic        tb_ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    logic [31:0] exp_rd_q[$];
    logic [1:0]  exp_rr_q[$];
    logic [1:0]  exp_b_q[$];

    always #5 tb_ACLK = ~tb_ACLK;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    multiply_axi_slave dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input int hold, input string tag);
        int n;
        logic [1:0] exr;
        exp_b_q.push_back(er);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = (hold == 0);
        n = 0;
        while (S_AXI_AWREADY !== 1'b1 && n < LIM) begin tick(); n++; end
        chk(64'(n < LIM), 64'd1, {tag, "_aw_timeout"});
        chk(64'(S_AXI_WREADY), 64'd1, {tag, "_wready"});
        tick();
        acc_cyc = cyc;
        if (hold == 0) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
        n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < LIM) begin tick(); n++; end
        chk(64'(n < LIM), 64'd1, {tag, "_b_timeout"});
        exr = exp_b_q.pop_front();
        chk(64'(S_AXI_BRESP), 64'(exr), {tag, "_bresp"});
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY}, {1'b1, exr, 1'b0}, {tag, "_bhold"});
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        tick();
        chk(64'(S_AXI_BVALID), 64'd0, {tag, "_bdrain"});
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er,
                            input int hold, input string tag);
        int n;
        logic [31:0] ex;
        logic [1:0]  exr;
        exp_rd_q.push_back(ed);
        exp_rr_q.push_back(er);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY = (hold == 0);
        n = 0;
        while (S_AXI_ARREADY !== 1'b1 && n < LIM) begin tick(); n++; end
        chk(64'(n < LIM), 64'd1, {tag, "_ar_timeout"});
        tick();
        if (hold == 0) S_AXI_ARVALID = 1'b0;
        n = 0;
        while (S_AXI_RVALID !== 1'b1 && n < LIM) begin tick(); n++; end
        chk(64'(n < LIM), 64'd1, {tag, "_r_timeout"});
        ex  = exp_rd_q.pop_front();
        exr = exp_rr_q.pop_front();
        chk(64'(S_AXI_RDATA), 64'(ex), tag);
        chk(64'(S_AXI_RRESP), 64'(exr), {tag, "_rresp"});
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY}, {1'b1, ex, 1'b0}, {tag, "_rhold"});
        end
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        tick();
        chk(64'(S_AXI_RVALID), 64'd0, {tag, "_rdrain"});
    endtask

    function automatic logic [43:0] all_outs();
        return {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, 3'b000};
    endfunction

    initial begin
        int n;
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        repeat (3) tick();
        chk(64'(all_outs()), 64'd0, "reset_outputs");
        ARESETN = 1'b1;
        tick();
        axi_read(5'h00, 32'h0, 2'b00, 0, "rst_opa");
        axi_read(5'h08, 32'h0, 2'b00, 0, "rst_ctrl");
        axi_read(5'h0C, 32'h0, 2'b00, 0, "rst_res_lo");

        // 3 * 5 with a BUSY poll mid-run
        axi_write(5'h00, 32'd3, 4'hF, 2'b00, 0, "w_opa3");
        axi_write(5'h04, 32'd5, 4'hF, 2'b00, 0, "w_opb5");
        axi_write(5'h08, 32'd1, 4'hF, 2'b00, 0, "w_start1");
        axi_read(5'h08, 32'h2, 2'b00, 0, "ctrl_busy");
        repeat (40) tick();
        axi_read(5'h08, 32'h4, 2'b00, 0, "ctrl_done");
        axi_read(5'h0C, 32'h0000000F, 2'b00, 0, "res_lo_15");
        axi_read(5'h10, 32'h0, 2'b00, 0, "res_hi_15");

        // Max operands and exact completion latency
        axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 0, "w_opa_max");
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 0, "w_opb_max");
        axi_write(5'h08, 32'd1, 4'hF, 2'b00, 0, "w_start2");
        n = 0;
        while (dut.ctrl_done !== 1'b1 && n < 100) begin tick(); n++; end
        chk(64'(n < 100), 64'd1, "done_timeout");
        chk(64'(cyc - acc_cyc + 1), 64'd33, "done_latency");
        axi_read(5'h0C, 32'h00000001, 2'b00, 0, "res_lo_max");
        axi_read(5'h10, 32'hFFFFFFFE, 2'b00, 0, "res_hi_max");

        // START and operand writes while busy must not disturb the run
        axi_write(5'h00, 32'd6, 4'hF, 2'b00, 0, "w_opa6");
        axi_write(5'h04, 32'd7, 4'hF, 2'b00, 0, "w_opb7");
        axi_write(5'h08, 32'd1, 4'hF, 2'b00, 0, "w_start3");
        axi_read(5'h0C, 32'h00000001, 2'b00, 0, "res_lo_held");
        axi_write(5'h00, 32'd100, 4'hF, 2'b00, 0, "w_opa_busy");
        axi_write(5'h08, 32'd1, 4'hF, 2'b00, 0, "w_start_busy");
        repeat (40) tick();
        axi_read(5'h0C, 32'd42, 2'b00, 0, "res_lo_42");
        axi_read(5'h10, 32'd0, 2'b00, 0, "res_hi_42");
        axi_read(5'h00, 32'd100, 2'b00, 0, "opa_after_busy");
        axi_write(5'h08, 32'h4, 4'hF, 2'b00, 0, "w_clr_done");
        axi_read(5'h08, 32'h0, 2'b00, 0, "ctrl_cleared");
        axi_read(5'h0C, 32'd42, 2'b00, 0, "res_lo_keep");

        // Byte strobes
        axi_write(5'h00, 32'h11223344, 4'hF, 2'b00, 0, "w_opa_full");
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 2'b00, 0, "w_opa_strb");
        axi_read(5'h00, 32'h11BB33DD, 2'b00, 0, "opa_strb");

        // Unmapped and read-only addresses
        axi_read(5'h14, 32'h0, 2'b10, 0, "rd_unmapped14");
        axi_read(5'h1C, 32'h0, 2'b10, 0, "rd_unmapped1c");
        axi_write(5'h0C, 32'hDEADBEEF, 4'hF, 2'b00, 0, "w_res_lo");
        axi_write(5'h18, 32'hDEADBEEF, 4'hF, 2'b10, 0, "w_unmapped18");
        axi_read(5'h0C, 32'd42, 2'b00, 0, "res_lo_ro");

        // Response backpressure
        axi_write(5'h04, 32'hCAFE0001, 4'hF, 2'b00, 5, "w_bhold");
        axi_read(5'h04, 32'hCAFE0001, 2'b00, 5, "r_hold");

        // Asynchronous reset in the middle of a run with a read response pending
        axi_write(5'h00, 32'd9, 4'hF, 2'b00, 0, "w_opa9");
        axi_write(5'h04, 32'd9, 4'hF, 2'b00, 0, "w_opb9");
        axi_write(5'h08, 32'd1, 4'hF, 2'b00, 0, "w_start4");
        S_AXI_RREADY = 1'b0;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (S_AXI_ARREADY !== 1'b1 && n < LIM) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        chk({S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'd9}, "pre_reset_r");
        while (cyc < acc_cyc + 9) tick();
        #2 ARESETN = 1'b0;
        #1;
        chk(64'(all_outs()), 64'd0, "async_reset_outputs");
        S_AXI_RREADY = 1'b1;
        repeat (3) tick();
        ARESETN = 1'b1;
        tick();
        axi_read(5'h08, 32'h0, 2'b00, 0, "post_rst_ctrl");
        axi_read(5'h0C, 32'h0, 2'b00, 0, "post_rst_res_lo");
        axi_read(5'h10, 32'h0, 2'b00, 0, "post_rst_res_hi");
        repeat (40) tick();
        axi_read(5'h08, 32'h0, 2'b00, 0, "post_rst_no_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
